// File: rtl/mmio_uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : mmio_uart_tx_if
// Description : Core data-memory port as seen by the MMIO UART transmitter.
//               The core (master) drives strobes, address and store data.
//               The peripheral (slave) returns load data and its window hit.
// Revision    : 1.0 - initial release
// ============================================================================
interface mmio_uart_tx_if;
  logic        memory_read;
  logic        memory_write;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        selected;

  modport master (
    output memory_read,
    output memory_write,
    output address,
    output write_data,
    input  read_data,
    input  selected
  );

  modport slave (
    input  memory_read,
    input  memory_write,
    input  address,
    input  write_data,
    output read_data,
    output selected
  );
endinterface
`default_nettype wire

// File: rtl/mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : mmio_uart_tx
// Description : Memory-mapped 8N1 UART transmitter. Stores to TXDATA queue a
//               byte in a small FIFO; an FSM drains the FIFO onto uart_tx.
//               STATUS exposes busy/full/empty/sticky overflow/count.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_uart_tx #(
  parameter int          CLOCK_FREQ   = 25000000,
  parameter int          BIT_RATE     = 115200,
  parameter logic [31:0] BASE_ADDRESS = 32'h80000000,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic                clk,
  input  logic                reset,
  mmio_uart_tx_if.slave       bus,
  output logic                uart_tx
);

  localparam int CLKS_PER_BIT = CLOCK_FREQ / BIT_RATE;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int PTR_W        = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // FIFO storage and bookkeeping
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             overflow;

  // Transmit FSM state and datapath
  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [CNT_W-1:0] baud_cnt;
  logic [CNT_W-1:0] baud_cnt_next;
  logic [2:0]       bit_idx;
  logic [2:0]       bit_idx_next;
  logic [7:0]       shift;
  logic [7:0]       shift_next;
  logic             tx_next;
  logic             busy;

  // Bus decode
  logic             addr_hit;
  logic [2:0]       offset;
  logic             store_txdata;
  logic             store_status;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             bit_done;
  logic [31:0]      count_wide;
  logic [3:0]       count_sat;
  logic [31:0]      status_word;
  logic             unused_write_data;

  assign addr_hit     = (bus.address[31:3] == BASE_ADDRESS[31:3]);
  assign offset       = bus.address[2:0];
  assign store_txdata = bus.memory_write && addr_hit && (offset == 3'h0);
  assign store_status = bus.memory_write && addr_hit && (offset == 3'h4);

  assign full  = (count == FIFO_FULL);
  assign empty = (count == '0);

  // A full FIFO drops the byte even if the FSM frees a slot on this edge.
  assign push = store_txdata && !full;
  assign pop  = (state == S_IDLE) && !empty;

  assign bit_done = (baud_cnt == CNT_LAST);

  assign count_wide  = 32'(count);
  assign count_sat   = (count_wide > 32'd15) ? 4'd15 : count_wide[3:0];
  assign status_word = {24'h0, count_sat, overflow, empty, full, busy};

  assign bus.selected  = addr_hit;
  assign bus.read_data = (bus.memory_read && addr_hit && (offset == 3'h4))
                         ? status_word : 32'h0;

  // Only the low byte and the overflow-clear bit of store data are consumed.
  assign unused_write_data = &{1'b0, bus.write_data[31:8]};

  // FIFO storage: written on accepted pushes, never reset (pointers gate it)
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= bus.write_data[7:0];
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (store_txdata && full) begin
        overflow <= 1'b1;
      end else if (store_status && bus.write_data[3]) begin
        overflow <= 1'b0;
      end
    end
  end

  // FSM state register, including the registered serial output
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      shift    <= 8'h00;
      uart_tx  <= 1'b1;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_cnt_next;
      bit_idx  <= bit_idx_next;
      shift    <= shift_next;
      uart_tx  <= tx_next;
    end
  end

  // FSM next-state and datapath update
  always_comb begin
    state_next    = state;
    baud_cnt_next = baud_cnt;
    bit_idx_next  = bit_idx;
    shift_next    = shift;
    case (state)
      S_IDLE: begin
        if (pop) begin
          state_next    = S_START;
          baud_cnt_next = '0;
          shift_next    = fifo_mem[rd_ptr];
        end
      end
      S_START: begin
        if (bit_done) begin
          state_next    = S_DATA;
          baud_cnt_next = '0;
          bit_idx_next  = 3'd0;
        end else begin
          baud_cnt_next = baud_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_done) begin
          baud_cnt_next = '0;
          shift_next    = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) begin
            state_next = S_STOP;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
          end
        end else begin
          baud_cnt_next = baud_cnt + 1'b1;
        end
      end
      default: begin
        if (bit_done) begin
          state_next    = S_IDLE;
          baud_cnt_next = '0;
        end else begin
          baud_cnt_next = baud_cnt + 1'b1;
        end
      end
    endcase
  end

  // FSM outputs: line level for the upcoming state, and busy flag
  always_comb begin
    tx_next = 1'b1;
    busy    = (state != S_IDLE);
    case (state_next)
      S_START: tx_next = 1'b0;
      S_DATA:  tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmio_uart_tx
// Description : Directed self-checking bench for mmio_uart_tx at 10 clocks
//               per bit: framing, FIFO fill/overflow, back-to-back spacing,
//               bus decode, reset abandonment and push-during-pop.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_uart_tx;

  localparam int CPB = 10;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic uart_tx;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  mmio_uart_tx_if bus();

  mmio_uart_tx #(
    .CLOCK_FREQ  (1000000),
    .BIT_RATE    (100000),
    .BASE_ADDRESS(32'h80000000),
    .FIFO_DEPTH  (8)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .uart_tx(uart_tx)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Free-running cycle counter for frame spacing measurements
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    bus.memory_write = 1'b1;
    bus.address      = addr;
    bus.write_data   = data;
    tick();
    bus.memory_write = 1'b0;
  endtask

  task automatic read_status(output logic [31:0] val);
    bus.memory_read = 1'b1;
    bus.address     = 32'h80000004;
    #1;
    val = bus.read_data;
    bus.memory_read = 1'b0;
  endtask

  task automatic wait_start(input string tag, input int budget);
    int n;
    n = 0;
    while (uart_tx !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    if (uart_tx !== 1'b0) check({tag, "_start_timeout"}, 32'(uart_tx), 32'h0);
  endtask

  // Checks bit slots first..9 of a frame (0=start, 1..8=data, 9=stop),
  // every cycle of each slot, plus STATUS.busy throughout.
  task automatic frame(input logic [7:0] b, input int first, input string tag);
    logic exp_bit;
    logic got_bit;
    logic busy_ok;
    busy_ok = 1'b1;
    bus.memory_read = 1'b1;
    bus.address     = 32'h80000004;
    #1;
    for (int bi = first; bi < 10; bi++) begin
      if (bi == 0)      exp_bit = 1'b0;
      else if (bi == 9) exp_bit = 1'b1;
      else              exp_bit = b[bi-1];
      got_bit = exp_bit;
      for (int c = 0; c < CPB; c++) begin
        if (uart_tx !== exp_bit) got_bit = uart_tx;
        if (bus.read_data[0] !== 1'b1) busy_ok = 1'b0;
        tick();
      end
      check($sformatf("%s_bit%0d", tag, bi), 32'(got_bit), 32'(exp_bit));
    end
    bus.memory_read = 1'b0;
    check({tag, "_busy"}, 32'(busy_ok), 32'h1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] st;
    int t1, t2;
    logic quiet;

    bus.memory_read  = 1'b0;
    bus.memory_write = 1'b0;
    bus.address      = 32'h0;
    bus.write_data   = 32'h0;

    // Reset state
    repeat (3) tick();
    check("rst_tx", 32'(uart_tx), 32'h1);
    read_status(st);
    check("rst_status", st, 32'h4);
    reset = 1'b1;
    tick();

    // 1. Single byte 0xA5
    store(32'h80000000, 32'h000000A5);
    check("t1_tx_idle", 32'(uart_tx), 32'h1);
    read_status(st);
    check("t1_status_queued", st, 32'h10);
    tick();
    check("t1_start_low", 32'(uart_tx), 32'h0);
    frame(8'hA5, 0, "t1");
    read_status(st);
    check("t1_status_done", st, 32'h4);
    check("t1_tx_high", 32'(uart_tx), 32'h1);

    // 2. Fill, overflow, overflow clear, drain in order
    for (int i = 1; i <= 9; i++) store(32'h80000000, 32'(i));
    read_status(st);
    check("t2_full", st, 32'h83);
    store(32'h80000000, 32'h0A);
    read_status(st);
    check("t2_overflow", st, 32'h8B);
    store(32'h80000004, 32'h8);
    read_status(st);
    check("t2_ovf_clear", st, 32'h83);
    tick();
    frame(8'h01, 1, "t2_b1");
    for (int i = 2; i <= 9; i++) begin
      wait_start($sformatf("t2_b%0d", i), 20);
      frame(8'(i), 0, $sformatf("t2_b%0d", i));
    end
    read_status(st);
    check("t2_drained", st, 32'h4);

    // 3. Back-to-back 0x55, 0xAA
    store(32'h80000000, 32'h55);
    store(32'h80000000, 32'hAA);
    wait_start("t3a", 5);
    t1 = cyc;
    frame(8'h55, 0, "t3a");
    wait_start("t3b", 5);
    t2 = cyc;
    check("t3_spacing", 32'(t2 - t1), 32'd101);
    frame(8'hAA, 0, "t3b");

    // 4. Bus decode
    bus.memory_read = 1'b1;
    bus.address = 32'h80000000; #1;
    check("t4_txdata_rd", bus.read_data, 32'h0);
    check("t4_sel_base", 32'(bus.selected), 32'h1);
    bus.address = 32'h7FFFFFFC; #1;
    check("t4_below_rd", bus.read_data, 32'h0);
    check("t4_below_sel", 32'(bus.selected), 32'h0);
    bus.address = 32'h80000004; #1;
    check("t4_status_rd", bus.read_data, 32'h4);
    bus.address = 32'h80000008; #1;
    check("t4_above_sel", 32'(bus.selected), 32'h0);
    bus.memory_read = 1'b0;
    store(32'h80000008, 32'h77);
    read_status(st);
    check("t4_no_push", st, 32'h4);
    repeat (3) tick();
    check("t4_line_idle", 32'(uart_tx), 32'h1);

    // 6. Push in the same cycle the FSM pops the single queued byte
    store(32'h80000000, 32'h96);
    store(32'h80000000, 32'h69);
    read_status(st);
    check("t6_count_one", st, 32'h11);
    wait_start("t6a", 5);
    frame(8'h96, 0, "t6a");
    wait_start("t6b", 5);
    frame(8'h69, 0, "t6b");

    // 5. Reset during data bit 3 with a second byte still queued
    store(32'h80000000, 32'h35);
    store(32'h80000000, 32'hC3);
    wait_start("t5", 5);
    repeat (44) tick();
    check("t5_bit3_low", 32'(uart_tx), 32'h0);
    reset = 1'b0;
    tick();
    check("t5_tx_reset", 32'(uart_tx), 32'h1);
    store(32'h80000000, 32'h5A);
    read_status(st);
    check("t5_store_in_reset", st, 32'h4);
    reset = 1'b1;
    tick();
    read_status(st);
    check("t5_status_after", st, 32'h4);
    quiet = 1'b1;
    repeat (150) begin
      if (uart_tx !== 1'b1) quiet = 1'b0;
      tick();
    end
    check("t5_line_quiet", 32'(quiet), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter that sits on the core's data-memory port, next to the data memory.
- Responds to core load/store accesses in its address window and buffers written bytes in a FIFO.
- Serializes each byte as 8N1 on uart_tx.
- Gives firmware a console output path. The core initiates; this block is the responder and the reader of the store data.

Parameters:
- CLOCK_FREQ, 25000000, clk frequency in Hz.
- BIT_RATE, 115200, serial bit rate. CLKS_PER_BIT = CLOCK_FREQ/BIT_RATE (integer division), and must be ≥ 2.
- BASE_ADDRESS, 32'h80000000, base of the 8-byte register window.
- FIFO_DEPTH, 8, TX FIFO entries. Must be a power of 2 and ≥ 2.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on the rising edge of clk).
- memory_read  input  1  core load strobe.
- memory_write  input  1  core store strobe.
- address  input  32  byte address from the core ALU.
- write_data  input  32  store data from the core register file.
- read_data  output  32  load data, combinational.
- selected  output  1  combinational: address[31:3] == BASE_ADDRESS[31:3].
- uart_tx  output  1  serial line, idle high.

Behaviour:

Register map (offset = address[2:0]; offsets other than 0 and 4 read 0, writes ignored):
- 0x0 TXDATA (write-only, reads 0): a store pushes write_data[7:0] into the FIFO.
- 0x4 STATUS:
  - bit0 busy (FSM not IDLE)
  - bit1 full
  - bit2 empty
  - bit3 overflow (sticky)
  - bits[7:4] count (FIFO entries, saturating at 15)
  - remaining bits 0
  - A store with write_data[3]=1 clears overflow; other bits are read-only.

Bus:
- Single-cycle and no wait states; stores take effect at the rising edge where memory_write=1 and selected=1.
- read_data = STATUS/0 when memory_read & selected, else 32'h0. No side effects on read.

FIFO:
- Push when the TXDATA store occurs and full=0, judged on pre-edge state.
- If full=1, the byte is dropped and overflow is set, even if the FSM pops in the same cycle.
- Simultaneous push and pop when not full: count unchanged; ordering is preserved.
- Read/write pointers wrap modulo FIFO_DEPTH.

TX FSM, states IDLE, START, DATA, STOP; baud counter 0..CLKS_PER_BIT-1; bit index 0..7:
- IDLE: uart_tx=1. If empty=0, pop the head into the shift register at this edge, go to START, and clear the counter.
- START: uart_tx=0 for CLKS_PER_BIT cycles, then go to DATA with index=0.
- DATA: uart_tx = shift[0], LSB first; each bit is held CLKS_PER_BIT cycles. After bit 7, go to STOP.
- STOP: uart_tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- uart_tx is registered (driven from a flop), glitch-free.

Latency:
- Store at edge E0 → FIFO non-empty after E0.
- FSM pops at E1 → uart_tx low from E1.
- Frame = 10*CLKS_PER_BIT cycles. Back-to-back frames have exactly 1 IDLE cycle between them (start-edge spacing 10*CLKS_PER_BIT+1).

Reset (reset=0 at an edge) — values in effect after that edge:
- FSM=IDLE, uart_tx=1, counters and index 0, pointers 0, count 0, overflow 0.
- read_data and selected are combinational and unaffected.
- A frame interrupted mid-transmission is abandoned; uart_tx returns high at that edge.
- Queued bytes are discarded.
- Stores during reset are ignored.

Test Plan:
Bench uses CLOCK_FREQ=1000000, BIT_RATE=100000 (CLKS_PER_BIT=10).

1. Single byte: store 0x000000A5 to 0x80000000.
   - uart_tx low one cycle later for 10 cycles.
   - Bits 1,0,1,0,0,1,0,1 (LSB first), 10 cycles each.
   - Stop high; busy=1 throughout, then STATUS reads 0x00000004.
2. Fill: 9 stores 0x01..0x09 in consecutive cycles.
   - First is popped by the FSM after one cycle, so all 9 are accepted; overflow=0.
   - Tenth store while count=8 → dropped, STATUS bit3=1.
   - Store 0x8 to 0x80000004 clears bit3.
3. Back-to-back: queue 0x55 and 0xAA.
   - Serial output decodes 0x55 then 0xAA.
   - Second start bit falls exactly 101 cycles after the first.
4. Bus decode:
   - Loads from 0x80000000 and 0x7FFFFFFC return 0 (0x7FFFFFFC also has selected=0).
   - Load from 0x80000004 while idle returns 0x4.
   - Store to 0x80000008 → no push, count stays 0.
5. Reset mid-frame: reset=0 during DATA bit 3.
   - uart_tx=1 after that edge; STATUS=0x4 after release.
   - No further line activity.
6. Push while popping: FIFO holds 1 byte and the FSM pops in the same cycle a store arrives.
   - count stays 1; both bytes transmitted in order.
